// File: rtl/delay_qual_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_qual_if
// Purpose  : Channel bundle for delay_qual (tick, raw inputs, qualified
//            outputs). Edge strobes exist only when DELAY_QUAL_EDGE_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
interface delay_qual_if #(
    parameter int W = 4
);
    logic         i_tick;
    logic [W-1:0] i_in;
    logic [W-1:0] o_out;
    logic [W-1:0] o_pending;
`ifdef DELAY_QUAL_EDGE_EN
    logic [W-1:0] o_rise;
    logic [W-1:0] o_fall;

    modport master (output i_tick, i_in, input o_out, o_pending, o_rise, o_fall);
    modport slave  (input i_tick, i_in, output o_out, o_pending, o_rise, o_fall);
`else
    modport master (output i_tick, i_in, input o_out, o_pending);
    modport slave  (input i_tick, i_in, output o_out, o_pending);
`endif
endinterface
`default_nettype wire

// File: rtl/delay_qual.sv
`default_nettype none
// ============================================================================
// Module   : delay_qual
// Purpose  : W-channel input qualifier with separate rise/fall delays counted
//            on i_tick. Optional macro DELAY_QUAL_EDGE_EN adds o_rise/o_fall.
// Revision : 1.0 - initial release
// ============================================================================
module delay_qual #(
    parameter int           W         = 4,
    parameter int           N_RISE    = 5,
    parameter int           N_FALL    = 0,
    parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
    input  wire logic    i_clk,
    input  wire logic    i_reset,
    delay_qual_if.slave  bus
);
    localparam int c_max_n = (N_RISE > N_FALL) ? N_RISE : N_FALL;
    localparam int c_cnt_w = $clog2(c_max_n + 1) + 1;

    localparam logic [c_cnt_w-1:0] c_rise_t = c_cnt_w'(N_RISE);
    localparam logic [c_cnt_w-1:0] c_fall_t = c_cnt_w'(N_FALL);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    logic [W-1:0]       r_out;
    logic [W-1:0]       r_pending;
    logic [c_cnt_w-1:0] r_cnt   [W];
    logic [c_cnt_w-1:0] w_cnt   [W];
    logic [c_cnt_w-1:0] w_tgt   [W];
    logic [W-1:0]       w_out;
    logic [W-1:0]       w_pending;

    // Agreement always clears the count, ticked or not, so a glitch restarts qualification.
    always_comb begin
        for (int k = 0; k < W; k++) begin
            w_tgt[k]     = r_out[k] ? c_fall_t : c_rise_t;
            w_cnt[k]     = r_cnt[k];
            w_out[k]     = r_out[k];
            if (bus.i_in[k] == r_out[k]) begin
                w_cnt[k] = '0;
            end else if (w_tgt[k] == '0) begin
                w_out[k] = bus.i_in[k];
                w_cnt[k] = '0;
            end else if (bus.i_tick) begin
                if (r_cnt[k] == w_tgt[k] - c_one) begin
                    w_out[k] = bus.i_in[k];
                    w_cnt[k] = '0;
                end else begin
                    w_cnt[k] = r_cnt[k] + c_one;
                end
            end
            w_pending[k] = (w_cnt[k] != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out     <= RESET_VAL;
            r_pending <= '0;
            for (int k = 0; k < W; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_out     <= w_out;
            r_pending <= w_pending;
            for (int k = 0; k < W; k++) begin
                r_cnt[k] <= w_cnt[k];
            end
        end
    end

    assign bus.o_out     = r_out;
    assign bus.o_pending = r_pending;

`ifdef DELAY_QUAL_EDGE_EN
    logic [W-1:0] r_rise;
    logic [W-1:0] r_fall;

    // Strobes come from the committed transition only, never from the reset load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_out & ~r_out;
            r_fall <= ~w_out & r_out;
        end
    end

    assign bus.o_rise = r_rise;
    assign bus.o_fall = r_fall;
`endif
endmodule
`default_nettype wire

// File: tb/tb_delay_qual.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_qual
// Purpose  : Self-checking bench for delay_qual: two builds (fall delay 0 with
//            reset 0000, fall delay 3 with reset 1010) sharing clock and tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_qual;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    delay_qual_if #(.W(4)) bus_a ();
    delay_qual_if #(.W(4)) bus_b ();

    delay_qual #(.W(4), .N_RISE(5), .N_FALL(0), .RESET_VAL(4'b0000)) dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_a.slave)
    );

    delay_qual #(.W(4), .N_RISE(5), .N_FALL(3), .RESET_VAL(4'b1010)) dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_b.slave)
    );

    typedef struct {
        bit         sel;
        bit         rst;
        bit         tick;
        logic [3:0] in;
        logic [3:0] eo;
        logic [3:0] ep;
    } vec_t;

    typedef struct {
        bit         sel;
        logic [3:0] eo;
        logic [3:0] ep;
        logic [3:0] er;
        logic [3:0] ef;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    logic [3:0] prev_a = 4'b0000;
    logic [3:0] prev_b = 4'b0000;

    task automatic add(input bit sel, input bit r, input bit t,
                       input logic [3:0] in, input logic [3:0] eo, input logic [3:0] ep);
        vec_t v;
        v.sel = sel; v.rst = r; v.tick = t; v.in = in; v.eo = eo; v.ep = ep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp_v);
        end
    endtask

    // Drive one cycle on the selected build; the other keeps its (agreeing) input.
    task automatic step(input bit sel, input bit r, input bit t,
                        input logic [3:0] in, input logic [3:0] eo, input logic [3:0] ep);
        exp_t       e;
        logic [3:0] prev;
        rst          = r;
        bus_a.i_tick = t;
        bus_b.i_tick = t;
        if (sel) bus_b.i_in = in;
        else     bus_a.i_in = in;
        prev  = sel ? prev_b : prev_a;
        e.sel = sel;
        e.eo  = eo;
        e.ep  = ep;
        e.er  = r ? 4'b0000 : (eo & ~prev);
        e.ef  = r ? 4'b0000 : (~eo & prev);
        if (sel) prev_b = eo;
        else     prev_a = eo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.sel) begin
            chk("b_out", bus_b.o_out, e.eo);
            chk("b_pending", bus_b.o_pending, e.ep);
`ifdef DELAY_QUAL_EDGE_EN
            chk("b_rise", bus_b.o_rise, e.er);
            chk("b_fall", bus_b.o_fall, e.ef);
`endif
        end else begin
            chk("a_out", bus_a.o_out, e.eo);
            chk("a_pending", bus_a.o_pending, e.ep);
`ifdef DELAY_QUAL_EDGE_EN
            chk("a_rise", bus_a.o_rise, e.er);
            chk("a_fall", bus_a.o_fall, e.ef);
`endif
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus_a.i_tick = 1'b1;
        bus_b.i_tick = 1'b1;
        bus_a.i_in   = 4'b0000;
        bus_b.i_in   = 4'b1010;

        // Reset state of both builds
        add(0, 1, 1, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1, 1, 4'b1010, 4'b1010, 4'b0000);
        // ch0 rise after 5 edges, pending on the 4 before; immediate release
        for (int i = 0; i < 4; i++) add(0, 0, 1, 4'b0001, 4'b0000, 4'b0001);
        add(0, 0, 1, 4'b0001, 4'b0001, 4'b0000);
        add(0, 0, 1, 4'b0000, 4'b0000, 4'b0000);
        // ch1 glitch: high 3, low 1, high 5
        for (int i = 0; i < 3; i++) add(0, 0, 1, 4'b0010, 4'b0000, 4'b0010);
        add(0, 0, 1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 4'b0010, 4'b0000, 4'b0010);
        add(0, 0, 1, 4'b0010, 4'b0010, 4'b0000);
        add(0, 0, 1, 4'b0000, 4'b0000, 4'b0000);
        // Build B ch3: low 2 then high keeps output; low 3 falls on 3rd edge
        for (int i = 0; i < 2; i++) add(1, 0, 1, 4'b0010, 4'b1010, 4'b1000);
        add(1, 0, 1, 4'b1010, 4'b1010, 4'b0000);
        for (int i = 0; i < 2; i++) add(1, 0, 1, 4'b0010, 4'b1010, 4'b1000);
        add(1, 0, 1, 4'b0010, 4'b0010, 4'b0000);
        // Build B ch0: count to 3, reset, then full 5-edge requalification
        for (int i = 0; i < 3; i++) add(1, 0, 1, 4'b0011, 4'b0010, 4'b0001);
        add(1, 1, 1, 4'b1011, 4'b1010, 4'b0000);
        for (int i = 0; i < 4; i++) add(1, 0, 1, 4'b1011, 4'b1010, 4'b0001);
        add(1, 0, 1, 4'b1011, 4'b1011, 4'b0000);

        foreach (vecs[i]) step(vecs[i].sel, vecs[i].rst, vecs[i].tick,
                               vecs[i].in, vecs[i].eo, vecs[i].ep);

        // Prescaled ch2: tick every 4th cycle, non-tick glitch after two ticks
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 3; c++)
                step(0, 0, 0, 4'b0100, 4'b0000, (p > 0) ? 4'b0100 : 4'b0000);
            step(0, 0, 1, 4'b0100, 4'b0000, 4'b0100);
        end
        step(0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        for (int j = 1; j <= 5; j++) begin
            for (int c = 0; c < 3; c++)
                step(0, 0, 0, 4'b0100, 4'b0000, (j > 1) ? 4'b0100 : 4'b0000);
            step(0, 0, 1, 4'b0100, (j == 5) ? 4'b0100 : 4'b0000,
                 (j == 5) ? 4'b0000 : 4'b0100);
        end
        step(0, 0, 1, 4'b0000, 4'b0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
